riscv_xc_init_seq: RTL and testbench



---
 rtl/riscv_xc_init_seq.sv | 93 +++++++++
 tb/tb_riscv_xc_init_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_xc_init_seq.sv
// rtl/riscv_xc_init_seq.sv - XCrypto register-file init sequencer
// Clears selected XC registers one per cycle through the shared W2 write port.
module riscv_xc_init_seq #(
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_XC_WORDS = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req_i,
  input  logic [15:0]           init_mask_i,
  input  logic                  abort_i,
  input  logic                  ext_we_i,
  output logic                  init_ack_o,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_n;
  logic [3:0]  r_idx, w_idx_n;
  logic [15:0] r_mask, w_mask_n;
  logic        w_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_mask  <= 16'd0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_mask  <= w_mask_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_mask_n  = r_mask;
    w_ack     = 1'b0;
    we_o      = 1'b0;
    done_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (init_req_i) begin
          w_ack     = 1'b1;
          w_mask_n  = init_mask_i;
          w_idx_n   = 4'd0;
          w_state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        // abort beats a pipeline writeback; a yield freezes idx so latency stays 16 issue slots
        if (abort_i) begin
          w_idx_n   = 4'd0;
          w_state_n = S_IDLE;
        end else if (!ext_we_i) begin
          we_o    = r_mask[r_idx];
          w_idx_n = r_idx + 4'd1;
          if (r_idx == 4'(NUM_XC_WORDS - 1)) begin
            w_state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_o    = ~abort_i;
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // no request is visible while reset is held
  assign init_ack_o = w_ack & ~rst;
  assign busy_o     = (r_state == S_SCAN) || (r_state == S_DONE);
  assign stall_o    = busy_o;
  assign waddr_o    = {1'b1, {(ADDR_WIDTH-5){1'b0}}, r_idx};
  assign wdata_o    = CLEAR_VALUE;

endmodule

// File: tb/tb_riscv_xc_init_seq.sv
// tb/tb_riscv_xc_init_seq.sv - self-checking bench for riscv_xc_init_seq
// Table-driven scenarios, randomized masks/yields/aborts, hand-written corner cases.
module tb_riscv_xc_init_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req_i;
  logic [15:0] init_mask_i;
  logic        abort_i;
  logic        ext_we_i;
  logic        init_ack_o;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic        we_o;
  logic [6:0]  waddr_o;
  logic [31:0] wdata_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_xc_init_seq dut (
    .clk         (clk),
    .rst         (rst),
    .init_req_i  (init_req_i),
    .init_mask_i (init_mask_i),
    .abort_i     (abort_i),
    .ext_we_i    (ext_we_i),
    .init_ack_o  (init_ack_o),
    .busy_o      (busy_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o)
  );

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          y0;
    int          y1;
    int          ab;
    int          exp_nwr;
    int          exp_done;
    int          exp_last_t;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one request at t0 with yield bits yv[t] and abort at cycle ab (0 = none).
  // The expected trace is built from the rule "16 non-yield slots, slot k writes 64+k if mask[k]".
  task automatic run_seq(input string nm, input logic [15:0] m, input logic [39:0] yv,
                         input int ab, output int nwr, output int dn, output int last_t);
    int wa[$];
    int wt[$];
    int ea[$];
    int et[$];
    int ex_done = -1;
    int ex_end  = 39;
    int p       = 0;
    int busy_bad = 0;
    int data_bad = 0;
    dn = -1;
    for (int t = 1; t < 40; t++) begin
      if (p == 16) begin
        ex_end = t;
        if (t != ab) ex_done = t;
        break;
      end
      if (t == ab) begin
        ex_end = t;
        break;
      end
      if (yv[t]) continue;
      if (m[p]) begin
        ea.push_back(64 + p);
        et.push_back(t);
      end
      p++;
    end

    init_req_i  = 1'b1;
    init_mask_i = m;
    ext_we_i    = 1'b0;
    abort_i     = 1'b0;
    @(negedge clk);
    chk({nm, " ack"}, init_ack_o, 1);
    next_cycle();
    init_req_i = 1'b0;
    for (int t = 1; t < 40; t++) begin
      ext_we_i = yv[t];
      abort_i  = (t == ab);
      @(negedge clk);
      if (we_o) begin
        wa.push_back(int'(waddr_o));
        wt.push_back(t);
        if (wdata_o !== 32'h0) data_bad++;
      end
      if (done_o) dn = t;
      if (busy_o !== (t <= ex_end) || stall_o !== busy_o) busy_bad++;
      next_cycle();
    end
    ext_we_i = 1'b0;
    abort_i  = 1'b0;

    nwr    = wa.size();
    last_t = (wt.size() > 0) ? wt[wt.size()-1] : -1;
    chk({nm, " model nwrites"}, nwr, ea.size());
    if (wa.size() == ea.size()) begin
      for (int i = 0; i < wa.size(); i++) begin
        chk({nm, " waddr"}, wa[i], ea[i]);
        chk({nm, " wtime"}, wt[i], et[i]);
      end
    end
    chk({nm, " model done"}, dn, ex_done);
    chk({nm, " busy/stall"}, busy_bad, 0);
    chk({nm, " wdata"}, data_bad, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int nwr, dn, lt, cnt;
    logic [39:0] yv;
    int ab;

    vecs[0] = '{"full",       16'hFFFF, 0, 0, 0,  16, 17, 16};
    vecs[1] = '{"sparse",     16'h8001, 0, 0, 0,  2,  17, 16};
    vecs[2] = '{"yield",      16'hFFFF, 3, 4, 0,  16, 19, 18};
    vecs[3] = '{"abort",      16'hFFFF, 0, 0, 6,  5,  -1, 5};
    vecs[4] = '{"mask0",      16'h0000, 0, 0, 0,  0,  17, -1};
    vecs[5] = '{"abort_done", 16'hFFFF, 0, 0, 17, 16, -1, 16};
    vecs[6] = '{"abort_yld",  16'hFFFF, 6, 0, 6,  5,  -1, 5};

    rst = 1'b1;
    init_req_i  = 1'b1;
    init_mask_i = 16'hFFFF;
    abort_i     = 1'b0;
    ext_we_i    = 1'b0;
    #2;
    chk("reset ack", init_ack_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset we", we_o, 0);
    chk("reset done", done_o, 0);
    init_req_i = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();

    foreach (vecs[i]) begin
      yv = '0;
      if (vecs[i].y0 != 0) yv[vecs[i].y0] = 1'b1;
      if (vecs[i].y1 != 0) yv[vecs[i].y1] = 1'b1;
      run_seq(vecs[i].name, vecs[i].mask, yv, vecs[i].ab, nwr, dn, lt);
      chk({vecs[i].name, " nwrites"}, nwr, vecs[i].exp_nwr);
      chk({vecs[i].name, " done_t"}, dn, vecs[i].exp_done);
      chk({vecs[i].name, " last_wr_t"}, lt, vecs[i].exp_last_t);
    end

    for (int r = 0; r < 30; r++) begin
      yv = '0;
      for (int t = 1; t <= 20; t++) yv[t] = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 25)) : 0;
      run_seq("rand", 16'($urandom), yv, ab, nwr, dn, lt);
    end

    // abort at t6, new request at t7 must be accepted
    init_req_i = 1'b1;
    init_mask_i = 16'hFFFF;
    next_cycle();
    init_req_i = 1'b0;
    for (int t = 1; t < 6; t++) next_cycle();
    abort_i = 1'b1;
    @(negedge clk);
    chk("abort t6 we", we_o, 0);
    next_cycle();
    abort_i = 1'b0;
    init_req_i = 1'b1;
    @(negedge clk);
    chk("reacq ack t7", init_ack_o, 1);
    next_cycle();
    init_req_i = 1'b0;
    @(negedge clk);
    chk("reacq busy t8", busy_o, 1);
    chk("reacq we t8 addr64", {we_o, waddr_o}, {1'b1, 7'd64});
    abort_i = 1'b1;
    next_cycle();
    abort_i = 1'b0;

    // asynchronous reset mid-sequence
    init_req_i = 1'b1;
    next_cycle();
    init_req_i = 1'b0;
    for (int t = 1; t < 8; t++) next_cycle();
    @(negedge clk);
    chk("pre-reset we", we_o, 1);
    #4;
    rst = 1'b1;
    #1;
    chk("midreset we", we_o, 0);
    chk("midreset busy", busy_o, 0);
    chk("midreset done", done_o, 0);
    next_cycle();
    rst = 1'b0;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (we_o || busy_o || done_o) cnt++;
      next_cycle();
    end
    chk("post-reset idle", cnt, 0);

    // held request with mask 0: ack at t0 and t18 only
    init_req_i  = 1'b1;
    init_mask_i = 16'h0000;
    cnt = 0;
    dn  = -1;
    for (int t = 0; t <= 18; t++) begin
      @(negedge clk);
      if (t == 0) chk("held ack t0", init_ack_o, 1);
      else if (t == 18) chk("held ack t18", init_ack_o, 1);
      else if (init_ack_o) cnt++;
      if (we_o) cnt++;
      if (done_o) dn = t;
      next_cycle();
    end
    chk("held no extra ack/we", cnt, 0);
    chk("held done_t", dn, 17);
    init_req_i = 1'b0;
    abort_i = 1'b1;
    next_cycle();
    abort_i = 1'b0;
    @(negedge clk);
    chk("final idle", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
